// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle CPU: decode inputs in, datapath selects and enables out.
interface multicycle_control_if #(parameter int CNT_W = 32);
  logic [5:0]       Opcode;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             PCEn;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic             Halted;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Opcode, Zero, MemReady,
    output PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Halted, InstrCount
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           Halted, InstrCount
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset control FSM: 3-5 cycles per instruction plus one per memory wait cycle;
// stalls in FETCH/MEMRD/MEMWR until MemReady, counts retired instructions, parks in HALT on bad opcodes.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                 Clock,
  input  logic                 Reset,
  multicycle_control_if.master ctl
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t           state;
  state_t           state_nxt;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             retire;

  // The opcode is captured in DECODE so MEMADR can pick lw vs sw after IR inputs move on.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= FETCH;
      op_q  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE)
        op_q <= ctl.Opcode;
      if (retire)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign ctl.InstrCount = cnt;

  always_comb begin
    state_nxt       = state;
    retire          = 1'b0;
    ctl.PCWrite     = 1'b0;
    ctl.PCWriteCond = 1'b0;
    ctl.PCEn        = 1'b0;
    ctl.IorD        = 1'b0;
    ctl.MemRead     = 1'b0;
    ctl.MemWrite    = 1'b0;
    ctl.IRWrite     = 1'b0;
    ctl.MemtoReg    = 1'b0;
    ctl.RegDst      = 1'b0;
    ctl.RegWrite    = 1'b0;
    ctl.ALUSrcA     = 1'b0;
    ctl.ALUSrcB     = 2'b00;
    ctl.ALUOp       = 2'b00;
    ctl.PCSource    = 2'b00;
    ctl.Halted      = 1'b0;

    // Reset masks every request/enable, including the Mealy terms.
    if (!Reset) begin
      case (state)
        FETCH: begin
          ctl.MemRead = 1'b1;
          ctl.ALUSrcB = 2'b01;
          if (ctl.MemReady) begin
            ctl.IRWrite = 1'b1;
            ctl.PCWrite = 1'b1;
            ctl.PCEn    = 1'b1;
            state_nxt   = DECODE;
          end
        end
        DECODE: begin
          ctl.ALUSrcB = 2'b11;
          case (ctl.Opcode)
            OP_RTYPE:     state_nxt = EXEC;
            OP_LW, OP_SW: state_nxt = MEMADR;
            OP_BEQ:       state_nxt = BRANCH;
            OP_J:         state_nxt = JUMP;
            OP_ADDI:      state_nxt = ADDIEX;
            default:      state_nxt = HALT;
          endcase
        end
        MEMADR: begin
          ctl.ALUSrcA = 1'b1;
          ctl.ALUSrcB = 2'b10;
          state_nxt   = (op_q == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          ctl.MemRead = 1'b1;
          ctl.IorD    = 1'b1;
          if (ctl.MemReady)
            state_nxt = MEMWB;
        end
        MEMWB: begin
          ctl.RegWrite = 1'b1;
          ctl.MemtoReg = 1'b1;
          retire       = 1'b1;
          state_nxt    = FETCH;
        end
        MEMWR: begin
          ctl.MemWrite = 1'b1;
          ctl.IorD     = 1'b1;
          if (ctl.MemReady) begin
            retire    = 1'b1;
            state_nxt = FETCH;
          end
        end
        EXEC: begin
          ctl.ALUSrcA = 1'b1;
          ctl.ALUOp   = 2'b10;
          state_nxt   = RWB;
        end
        RWB: begin
          ctl.RegWrite = 1'b1;
          ctl.RegDst   = 1'b1;
          retire       = 1'b1;
          state_nxt    = FETCH;
        end
        BRANCH: begin
          ctl.ALUSrcA     = 1'b1;
          ctl.ALUOp       = 2'b01;
          ctl.PCWriteCond = 1'b1;
          ctl.PCEn        = ctl.Zero;
          ctl.PCSource    = 2'b01;
          retire          = 1'b1;
          state_nxt       = FETCH;
        end
        JUMP: begin
          ctl.PCWrite  = 1'b1;
          ctl.PCEn     = 1'b1;
          ctl.PCSource = 2'b10;
          retire       = 1'b1;
          state_nxt    = FETCH;
        end
        ADDIEX: begin
          ctl.ALUSrcA = 1'b1;
          ctl.ALUSrcB = 2'b10;
          state_nxt   = ADDIWB;
        end
        ADDIWB: begin
          ctl.RegWrite = 1'b1;
          retire       = 1'b1;
          state_nxt    = FETCH;
        end
        HALT: begin
          ctl.Halted = 1'b1;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state/output checks plus a narrow-counter wrap instance.
module tb_multicycle_control;
  logic Clock = 1'b0;
  logic Reset;
  logic Reset2;
  int   checks = 0;
  int   errors = 0;
  int   ir_cnt = 0;

  multicycle_control_if #(.CNT_W(32)) bus ();
  multicycle_control_if #(.CNT_W(3))  w ();

  multicycle_control #(.CNT_W(32)) dut  (.Clock(Clock), .Reset(Reset),  .ctl(bus));
  multicycle_control #(.CNT_W(3))  dutw (.Clock(Clock), .Reset(Reset2), .ctl(w));

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Drive MemReady for this cycle, then check the registered state.
  task automatic cyc(input logic mr, input logic [3:0] es, input string tag);
    bus.MemReady = mr;
    #1;
    chk(tag, 32'(dut.state), 32'(es));
    if (bus.IRWrite) ir_cnt++;
  endtask

  function automatic logic [6:0] enables();
    return {bus.PCWrite, bus.PCWriteCond, bus.PCEn, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.RegWrite};
  endfunction

  initial begin
    Reset = 1'b1;
    Reset2 = 1'b1;
    bus.Opcode = 6'b000000; bus.Zero = 1'b0; bus.MemReady = 1'b1;
    w.Opcode = 6'b000010;   w.Zero = 1'b0;   w.MemReady = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_state", 32'(dut.state), 32'd0);
    chk("rst_enables", 32'(enables()), 32'd0);
    chk("rst_halted", 32'(bus.Halted), 32'd0);
    chk("rst_count", bus.InstrCount, 32'd0);
    Reset = 1'b0;

    // add, MemReady held high: 0,1,6,7,0
    bus.Opcode = 6'b000000;
    cyc(1'b1, 4'd0, "add_s0");
    chk("add_irwrite", 32'(bus.IRWrite), 32'd1);
    chk("add_pcen", 32'(bus.PCEn), 32'd1);
    chk("add_srcb_f", 32'(bus.ALUSrcB), 32'd1);
    tick();
    cyc(1'b1, 4'd1, "add_s1");
    chk("add_srcb_d", 32'(bus.ALUSrcB), 32'd3);
    tick();
    cyc(1'b1, 4'd6, "add_s6");
    chk("add_aluop", 32'(bus.ALUOp), 32'd2);
    chk("add_srca", 32'(bus.ALUSrcA), 32'd1);
    tick();
    cyc(1'b1, 4'd7, "add_s7");
    chk("add_regwrite", 32'(bus.RegWrite), 32'd1);
    chk("add_regdst", 32'(bus.RegDst), 32'd1);
    chk("add_cnt_before", bus.InstrCount, 32'd0);
    tick();
    chk("add_cnt_after", bus.InstrCount, 32'd1);

    // lw with two FETCH waits and one MEMRD wait: 8 cycles
    bus.Opcode = 6'b100011;
    ir_cnt = 0;
    cyc(1'b0, 4'd0, "lw_f_wait0");
    chk("lw_wait_irwrite", 32'(bus.IRWrite), 32'd0);
    chk("lw_wait_pcen", 32'(bus.PCEn), 32'd0);
    chk("lw_wait_memread", 32'(bus.MemRead), 32'd1);
    tick();
    cyc(1'b0, 4'd0, "lw_f_wait1");
    tick();
    cyc(1'b1, 4'd0, "lw_f_go");
    tick();
    cyc(1'b1, 4'd1, "lw_decode");
    tick();
    cyc(1'b1, 4'd2, "lw_memadr");
    chk("lw_srcb", 32'(bus.ALUSrcB), 32'd2);
    tick();
    cyc(1'b0, 4'd3, "lw_memrd_wait");
    chk("lw_iord", 32'(bus.IorD), 32'd1);
    chk("lw_memrd_read", 32'(bus.MemRead), 32'd1);
    tick();
    cyc(1'b1, 4'd3, "lw_memrd_go");
    tick();
    cyc(1'b1, 4'd4, "lw_memwb");
    chk("lw_memtoreg", 32'(bus.MemtoReg), 32'd1);
    chk("lw_regwrite", 32'(bus.RegWrite), 32'd1);
    chk("lw_regdst", 32'(bus.RegDst), 32'd0);
    tick();
    chk("lw_done_state", 32'(dut.state), 32'd0);
    chk("lw_irwrite_pulses", ir_cnt, 32'd1);
    chk("lw_cnt", bus.InstrCount, 32'd2);

    // beq taken
    bus.Opcode = 6'b000100;
    cyc(1'b1, 4'd0, "beq1_f");
    tick();
    cyc(1'b1, 4'd1, "beq1_d");
    tick();
    bus.Zero = 1'b1;
    cyc(1'b1, 4'd8, "beq1_br");
    chk("beq1_pcen", 32'(bus.PCEn), 32'd1);
    chk("beq1_pcwc", 32'(bus.PCWriteCond), 32'd1);
    chk("beq1_pcsrc", 32'(bus.PCSource), 32'd1);
    chk("beq1_aluop", 32'(bus.ALUOp), 32'd1);
    tick();
    chk("beq1_done", 32'(dut.state), 32'd0);
    chk("beq1_cnt", bus.InstrCount, 32'd3);

    // beq not taken
    bus.Zero = 1'b0;
    cyc(1'b1, 4'd0, "beq0_f");
    tick();
    cyc(1'b1, 4'd1, "beq0_d");
    tick();
    cyc(1'b1, 4'd8, "beq0_br");
    chk("beq0_pcen", 32'(bus.PCEn), 32'd0);
    tick();
    chk("beq0_cnt", bus.InstrCount, 32'd4);

    // addi
    bus.Opcode = 6'b001000;
    cyc(1'b1, 4'd0, "addi_f");
    tick();
    cyc(1'b1, 4'd1, "addi_d");
    tick();
    cyc(1'b1, 4'd10, "addi_ex");
    chk("addi_srcb", 32'(bus.ALUSrcB), 32'd2);
    tick();
    cyc(1'b1, 4'd11, "addi_wb");
    chk("addi_regwrite", 32'(bus.RegWrite), 32'd1);
    chk("addi_regdst", 32'(bus.RegDst), 32'd0);
    tick();
    chk("addi_cnt", bus.InstrCount, 32'd5);

    // illegal opcode parks in HALT
    bus.Opcode = 6'b111111;
    cyc(1'b1, 4'd0, "ill_f");
    tick();
    cyc(1'b1, 4'd1, "ill_d");
    tick();
    for (int i = 0; i < 20; i++) begin
      cyc(1'(i & 1), 4'd12, "halt_state");
      chk("halt_halted", 32'(bus.Halted), 32'd1);
      chk("halt_enables", 32'(enables()), 32'd0);
      chk("halt_cnt", bus.InstrCount, 32'd5);
      tick();
    end

    // reset out of HALT
    Reset = 1'b1;
    bus.MemReady = 1'b1;
    tick();
    chk("hrst_state", 32'(dut.state), 32'd0);
    chk("hrst_halted", 32'(bus.Halted), 32'd0);
    chk("hrst_cnt", bus.InstrCount, 32'd0);
    Reset = 1'b0;

    // j
    bus.Opcode = 6'b000010;
    cyc(1'b1, 4'd0, "j_f");
    tick();
    cyc(1'b1, 4'd1, "j_d");
    tick();
    cyc(1'b1, 4'd9, "j_jump");
    chk("j_pcwrite", 32'(bus.PCWrite), 32'd1);
    chk("j_pcen", 32'(bus.PCEn), 32'd1);
    chk("j_pcsrc", 32'(bus.PCSource), 32'd2);
    tick();
    chk("j_cnt", bus.InstrCount, 32'd1);

    // sw abandoned by reset while waiting in MEMWR
    bus.Opcode = 6'b101011;
    cyc(1'b1, 4'd0, "sw_f");
    tick();
    cyc(1'b1, 4'd1, "sw_d");
    tick();
    cyc(1'b1, 4'd2, "sw_memadr");
    tick();
    cyc(1'b0, 4'd5, "sw_memwr");
    chk("sw_memwrite", 32'(bus.MemWrite), 32'd1);
    chk("sw_iord", 32'(bus.IorD), 32'd1);
    tick();
    cyc(1'b0, 4'd5, "sw_memwr_wait");
    Reset = 1'b1;
    #1;
    chk("sw_rst_memwrite", 32'(bus.MemWrite), 32'd0);
    tick();
    chk("sw_rst_state", 32'(dut.state), 32'd0);
    chk("sw_rst_cnt", bus.InstrCount, 32'd0);
    Reset = 1'b0;

    // 3-bit counter: seven jumps reach all-ones, the eighth wraps to zero
    Reset2 = 1'b0;
    repeat (21) tick();
    chk("wrap_max", 32'(w.InstrCount), 32'd7);
    repeat (3) tick();
    chk("wrap_zero", 32'(w.InstrCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
